pkt_hdr_stream_parser: RTL and testbench

// Parametrised successor to the fixed 32-bit packet parser. Sits between the padded-frame source and the payload FIFO/DMA.

---
 rtl/pkt_hdr_stream_parser.sv | 208 ++++++++++++++++++++
 tb/tb_pkt_hdr_stream_parser.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_hdr_stream_parser.sv
// Purpose    : split an MSB-first word stream into ETH/IP/TCP header registers and a payload stream.
// Latency    : payload word appears on data_out one cycle after it is accepted; headers/hdr_valid one cycle after the final TCP word.
// Backpressure: ready_in is always high in header/drop states; in payload it is !valid_out | ready_out (1-deep output register).
//
// Ports:
//   clk, rst                    clock (posedge) and asynchronous active-high reset
//   data_in/valid_in/last_in    input word stream, ready_in = parser accepts this cycle
//   data_out/valid_out/last_out payload stream, ready_out = downstream accepts
//   eth_hdr/ip_hdr/tcp_hdr      last completed headers, hdr_valid pulses when they update
//   pkt_err                     pulse on short or oversize packet
//   pkt_count                   good packets completed (wraps)
module pkt_hdr_stream_parser #(
   parameter int WIDTH         = 32,
   parameter int ETH_BITS      = 128,
   parameter int IP_BITS       = 160,
   parameter int TCP_BITS      = 160,
   parameter int MAX_PAY_WORDS = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [WIDTH-1:0]    data_in,
   input  logic                valid_in,
   input  logic                last_in,
   output logic                ready_in,
   output logic [WIDTH-1:0]    data_out,
   output logic                valid_out,
   output logic                last_out,
   input  logic                ready_out,
   output logic [ETH_BITS-1:0] eth_hdr,
   output logic [IP_BITS-1:0]  ip_hdr,
   output logic [TCP_BITS-1:0] tcp_hdr,
   output logic                hdr_valid,
   output logic                pkt_err,
   output logic [15:0]         pkt_count
);

   localparam int ETH_WORDS = ETH_BITS / WIDTH;
   localparam int IP_WORDS  = IP_BITS / WIDTH;
   localparam int TCP_WORDS = TCP_BITS / WIDTH;
   localparam int HMAX_A    = (ETH_WORDS > IP_WORDS) ? ETH_WORDS : IP_WORDS;
   localparam int HMAX      = (HMAX_A > TCP_WORDS) ? HMAX_A : TCP_WORDS;
   localparam int HCNT_W    = $clog2(HMAX + 1);
   localparam int PCNT_W    = $clog2(MAX_PAY_WORDS + 1);

   localparam logic [HCNT_W-1:0] ETH_LAST = HCNT_W'(ETH_WORDS - 1);
   localparam logic [HCNT_W-1:0] IP_LAST  = HCNT_W'(IP_WORDS - 1);
   localparam logic [HCNT_W-1:0] TCP_LAST = HCNT_W'(TCP_WORDS - 1);
   localparam logic [PCNT_W-1:0] PAY_LAST = PCNT_W'(MAX_PAY_WORDS - 1);

   typedef enum logic [2:0] {
      S_ETH  = 3'd0,
      S_IP   = 3'd1,
      S_TCP  = 3'd2,
      S_PAY  = 3'd3,
      S_DROP = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [HCNT_W-1:0]   r_hcnt;
   logic [PCNT_W-1:0]   r_pcnt;
   logic [ETH_BITS-1:0] r_eth_sh;
   logic [IP_BITS-1:0]  r_ip_sh;
   logic [TCP_BITS-1:0] r_tcp_sh;

   logic w_rdy;
   logic w_acc;
   logic w_hdr_state;
   logic w_tcp_done;   // final TCP word accepted
   logic w_short;      // last_in seen before the header was complete
   logic w_pay_good;   // last_in within the payload cap
   logic w_pay_cap;    // cap reached without last_in
   logic w_drop_end;   // last_in of an oversize packet

   // Payload words go through a single output register, so a new word can
   // only be taken when that register is empty or being emptied this cycle.
   assign w_rdy       = (r_state == S_PAY) ? (!valid_out || ready_out) : 1'b1;
   assign ready_in    = w_rdy && !rst;
   assign w_acc       = valid_in && ready_in;
   assign w_hdr_state = (r_state == S_ETH) || (r_state == S_IP) || (r_state == S_TCP);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_ETH;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_tcp_done  = 1'b0;
      w_short     = 1'b0;
      w_pay_good  = 1'b0;
      w_pay_cap   = 1'b0;
      w_drop_end  = 1'b0;
      case (r_state)
         S_ETH: begin
            if (w_acc) begin
               if (last_in) begin
                  w_short     = 1'b1;
                  w_state_nxt = S_ETH;
               end else if (r_hcnt == ETH_LAST) begin
                  w_state_nxt = S_IP;
               end
            end
         end
         S_IP: begin
            if (w_acc) begin
               if (last_in) begin
                  w_short     = 1'b1;
                  w_state_nxt = S_ETH;
               end else if (r_hcnt == IP_LAST) begin
                  w_state_nxt = S_TCP;
               end
            end
         end
         S_TCP: begin
            if (w_acc) begin
               if (r_hcnt == TCP_LAST) begin
                  w_tcp_done  = 1'b1;
                  w_state_nxt = last_in ? S_ETH : S_PAY;
               end else if (last_in) begin
                  w_short     = 1'b1;
                  w_state_nxt = S_ETH;
               end
            end
         end
         S_PAY: begin
            if (w_acc) begin
               // last_in takes priority: a packet ending exactly at the cap is good
               if (last_in) begin
                  w_pay_good  = 1'b1;
                  w_state_nxt = S_ETH;
               end else if (r_pcnt == PAY_LAST) begin
                  w_pay_cap   = 1'b1;
                  w_state_nxt = S_DROP;
               end
            end
         end
         S_DROP: begin
            if (w_acc && last_in) begin
               w_drop_end  = 1'b1;
               w_state_nxt = S_ETH;
            end
         end
         default: w_state_nxt = S_ETH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hcnt    <= '0;
         r_pcnt    <= '0;
         r_eth_sh  <= '0;
         r_ip_sh   <= '0;
         r_tcp_sh  <= '0;
         eth_hdr   <= '0;
         ip_hdr    <= '0;
         tcp_hdr   <= '0;
         hdr_valid <= 1'b0;
         pkt_err   <= 1'b0;
         pkt_count <= '0;
         data_out  <= '0;
         valid_out <= 1'b0;
         last_out  <= 1'b0;
      end else begin
         hdr_valid <= w_tcp_done;
         pkt_err   <= w_short || w_drop_end;

         if (w_acc && w_hdr_state) begin
            r_hcnt <= (last_in || (w_state_nxt != r_state)) ? '0 : r_hcnt + HCNT_W'(1);
         end

         // Shadow registers shift MSB-first; the truncating cast drops the oldest word.
         if (w_acc && (r_state == S_ETH)) r_eth_sh <= ETH_BITS'({r_eth_sh, data_in});
         if (w_acc && (r_state == S_IP))  r_ip_sh  <= IP_BITS'({r_ip_sh, data_in});
         if (w_acc && (r_state == S_TCP)) r_tcp_sh <= TCP_BITS'({r_tcp_sh, data_in});

         if (w_tcp_done) begin
            eth_hdr <= r_eth_sh;
            ip_hdr  <= r_ip_sh;
            tcp_hdr <= TCP_BITS'({r_tcp_sh, data_in});
         end

         if (w_short) begin
            r_eth_sh <= '0;
            r_ip_sh  <= '0;
            r_tcp_sh <= '0;
         end

         if ((w_tcp_done && last_in) || w_pay_good) begin
            pkt_count <= pkt_count + 16'd1;
         end

         if (w_acc && (r_state == S_PAY)) begin
            data_out  <= data_in;
            valid_out <= 1'b1;
            last_out  <= last_in || (r_pcnt == PAY_LAST);
            r_pcnt    <= (last_in || w_pay_cap) ? '0 : r_pcnt + PCNT_W'(1);
         end else if (ready_out) begin
            valid_out <= 1'b0;
            last_out  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pkt_hdr_stream_parser.sv
// Bench for pkt_hdr_stream_parser: a 32-bit instance (default headers) and a
// 64-bit instance. 160-bit headers are not whole 64-bit words, so the 64-bit
// instance uses 192-bit IP/TCP headers. Only one instance is exercised at a time.
module tb_pkt_hdr_stream_parser;

   localparam int MAXP = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [63:0] din  [2];
   logic        vin  [2];
   logic        lin  [2];
   logic        rout [2];

   logic         rin  [2];
   logic         vout [2];
   logic         lout [2];
   logic         hv   [2];
   logic         perr [2];
   logic [63:0]  dout [2];
   logic [15:0]  pc   [2];
   logic [191:0] ethv [2];
   logic [191:0] ipv  [2];
   logic [191:0] tcpv [2];

   wire          rin0, vout0, lout0, hv0, perr0;
   wire [31:0]   dout0;
   wire [15:0]   pc0;
   wire [127:0]  eth0;
   wire [159:0]  ip0, tcp0;
   wire          rin1, vout1, lout1, hv1, perr1;
   wire [63:0]   dout1;
   wire [15:0]   pc1;
   wire [127:0]  eth1;
   wire [191:0]  ip1, tcp1;

   pkt_hdr_stream_parser #(.WIDTH(32), .ETH_BITS(128), .IP_BITS(160), .TCP_BITS(160), .MAX_PAY_WORDS(MAXP)) u_dut32 (
      .clk(clk), .rst(rst),
      .data_in(din[0][31:0]), .valid_in(vin[0]), .last_in(lin[0]), .ready_in(rin0),
      .data_out(dout0), .valid_out(vout0), .last_out(lout0), .ready_out(rout[0]),
      .eth_hdr(eth0), .ip_hdr(ip0), .tcp_hdr(tcp0),
      .hdr_valid(hv0), .pkt_err(perr0), .pkt_count(pc0)
   );

   pkt_hdr_stream_parser #(.WIDTH(64), .ETH_BITS(128), .IP_BITS(192), .TCP_BITS(192), .MAX_PAY_WORDS(MAXP)) u_dut64 (
      .clk(clk), .rst(rst),
      .data_in(din[1]), .valid_in(vin[1]), .last_in(lin[1]), .ready_in(rin1),
      .data_out(dout1), .valid_out(vout1), .last_out(lout1), .ready_out(rout[1]),
      .eth_hdr(eth1), .ip_hdr(ip1), .tcp_hdr(tcp1),
      .hdr_valid(hv1), .pkt_err(perr1), .pkt_count(pc1)
   );

   assign rin[0] = rin0;   assign rin[1] = rin1;
   assign vout[0] = vout0; assign vout[1] = vout1;
   assign lout[0] = lout0; assign lout[1] = lout1;
   assign hv[0] = hv0;     assign hv[1] = hv1;
   assign perr[0] = perr0; assign perr[1] = perr1;
   assign dout[0] = {32'h0, dout0};
   assign dout[1] = dout1;
   assign pc[0] = pc0;     assign pc[1] = pc1;
   assign ethv[0] = {64'h0, eth0}; assign ethv[1] = {64'h0, eth1};
   assign ipv[0] = {32'h0, ip0};   assign ipv[1] = ip1;
   assign tcpv[0] = {32'h0, tcp0}; assign tcpv[1] = tcp1;

   int unsigned n_tot = 0;
   int unsigned n_bad = 0;

   task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [64:0]  qpay [$];   // {last, data}
   logic [191:0] qeth [$];
   logic [191:0] qip  [$];
   logic [191:0] qtcp [$];
   logic [191:0] last_eth, last_ip, last_tcp;
   int           exp_good [2];
   int           exp_err  [2];
   int           seen_err [2];
   int           rmode;
   int           gap_pct;

   function automatic int wbits(input int s);
      return (s == 0) ? 32 : 64;
   endfunction

   function automatic int hbits(input int s);   // IP and TCP header length
      return (s == 0) ? 160 : 192;
   endfunction

   // A packet of n words: header = first (128+2*hbits)/W words split into three
   // fields; payload = the rest, of which at most MAXP are forwarded.
   task automatic model_pkt(input int s, input logic [63:0] w [$]);
      int ne, ni, nt, nh, n, np, m;
      logic [191:0] e, i, t;
      ne = 128 / wbits(s);
      ni = hbits(s) / wbits(s);
      nt = ni;
      nh = ne + ni + nt;
      n  = w.size();
      if (n < nh) begin
         exp_err[s]++;
         return;
      end
      e = '0; i = '0; t = '0;
      for (int k = 0; k < ne; k++) e = (e << wbits(s)) | 192'(w[k]);
      for (int k = 0; k < ni; k++) i = (i << wbits(s)) | 192'(w[ne + k]);
      for (int k = 0; k < nt; k++) t = (t << wbits(s)) | 192'(w[ne + ni + k]);
      qeth.push_back(e); qip.push_back(i); qtcp.push_back(t);
      np = n - nh;
      m  = (np > MAXP) ? MAXP : np;
      for (int k = 0; k < m; k++) qpay.push_back({(k == m - 1), w[nh + k]});
      if (np > MAXP) exp_err[s]++;
      else           exp_good[s]++;
   endtask

   task automatic build_std(input int s, input int npay, output logic [63:0] w [$]);
      w = {};
      if (s == 0) begin
         for (int k = 0; k < 4; k++) w.push_back(64'h0000_0000_A1A1_A1A1);
         for (int k = 0; k < 5; k++) w.push_back(64'h0000_0000_B2B2_B2B2);
         for (int k = 0; k < 5; k++) w.push_back(64'h0000_0000_C3C3_C3C3);
         for (int k = 0; k < npay; k++) w.push_back(64'h0000_0000_D4F4_0099);
      end else begin
         for (int k = 0; k < 2; k++) w.push_back(64'hA1A1_A1A1_A1A1_A1A1);
         for (int k = 0; k < 3; k++) w.push_back(64'hB2B2_B2B2_B2B2_B2B2);
         for (int k = 0; k < 3; k++) w.push_back(64'hC3C3_C3C3_C3C3_C3C3);
         for (int k = 0; k < npay; k++) w.push_back(64'hD4F4_0099_D4F4_0099);
      end
   endtask

   task automatic build_rand(input int s, input int n, output logic [63:0] w [$]);
      w = {};
      for (int k = 0; k < n; k++) begin
         if (s == 0) w.push_back({32'h0, 32'($urandom)});
         else        w.push_back({32'($urandom), 32'($urandom)});
      end
   endtask

   // ---------------- driver (resumes at posedge+1) ----------------
   task automatic drive(input int s, input logic [63:0] w [$], input int upto);
      bit acc;
      int budget;
      for (int k = 0; k < upto; k++) begin
         while ($urandom_range(99) < gap_pct) begin
            @(posedge clk); #1;
         end
         vin[s] = 1'b1;
         din[s] = w[k];
         lin[s] = (k == w.size() - 1);
         acc = 1'b0;
         budget = 0;
         while (!acc) begin
            @(negedge clk);
            acc = rin[s];
            @(posedge clk); #1;
            budget++;
            if (!acc && budget > 200) begin
               chk("accept_timeout", 0, 1);
               break;
            end
         end
         vin[s] = 1'b0;
         lin[s] = 1'b0;
      end
   endtask

   task automatic send_pkt(input int s, input logic [63:0] w [$]);
      model_pkt(s, w);
      drive(s, w, w.size());
   endtask

   task automatic drain();
      int b = 0;
      while ((qpay.size() != 0 || qeth.size() != 0) && b < 1000) begin
         @(posedge clk); #1;
         b++;
      end
      repeat (4) begin
         @(posedge clk); #1;
      end
      chk("drain_pay_left", qpay.size(), 0);
      chk("drain_hdr_left", qeth.size(), 0);
      for (int s = 0; s < 2; s++) begin
         chk("pkt_count", pc[s], exp_good[s]);
         chk("err_pulses", seen_err[s], exp_err[s]);
      end
      qpay.delete(); qeth.delete(); qip.delete(); qtcp.delete();
   endtask

   task automatic zero_check(input string ph);
      for (int s = 0; s < 2; s++) begin
         chk({ph, "_ready_in"}, rin[s], 0);
         chk({ph, "_valid_out"}, vout[s], 0);
         chk({ph, "_last_out"}, lout[s], 0);
         chk({ph, "_hdr_valid"}, hv[s], 0);
         chk({ph, "_pkt_err"}, perr[s], 0);
         chk({ph, "_pkt_count"}, pc[s], 0);
         chk({ph, "_data_out"}, dout[s], 0);
         chk({ph, "_eth_hdr"}, ethv[s], 0);
         chk({ph, "_ip_hdr"}, ipv[s], 0);
         chk({ph, "_tcp_hdr"}, tcpv[s], 0);
      end
   endtask

   // ---------------- downstream ready driver ----------------
   initial begin
      forever begin
         @(posedge clk); #1;
         for (int s = 0; s < 2; s++) begin
            case (rmode)
               0:       rout[s] = 1'b1;
               1:       rout[s] = ~rout[s];
               default: rout[s] = 1'($urandom_range(1));
            endcase
         end
      end
   end

   // ---------------- monitor ----------------
   bit          stall_prev [2];
   logic [63:0] stall_dat  [2];
   logic        stall_lst  [2];
   initial begin
      logic [64:0] e;
      stall_prev[0] = 1'b0; stall_prev[1] = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stall_prev[0] = 1'b0; stall_prev[1] = 1'b0;
         end else begin
            for (int s = 0; s < 2; s++) begin
               if (hv[s]) begin
                  if (qeth.size() == 0) chk("hdr_unexpected", 1, 0);
                  else begin
                     last_eth = qeth.pop_front();
                     last_ip  = qip.pop_front();
                     last_tcp = qtcp.pop_front();
                     chk("eth_hdr", ethv[s], last_eth);
                     chk("ip_hdr", ipv[s], last_ip);
                     chk("tcp_hdr", tcpv[s], last_tcp);
                  end
               end
               if (perr[s]) seen_err[s]++;
               if (stall_prev[s]) begin
                  chk("stall_valid", vout[s], 1);
                  chk("stall_data", dout[s], stall_dat[s]);
                  chk("stall_last", lout[s], stall_lst[s]);
               end
               if (vout[s] && rout[s]) begin
                  if (qpay.size() == 0) chk("pay_unexpected", dout[s], 0);
                  else begin
                     e = qpay.pop_front();
                     chk("pay_data", dout[s], e[63:0]);
                     chk("pay_last", lout[s], e[64]);
                  end
               end
               stall_prev[s] = vout[s] && !rout[s];
               stall_dat[s]  = dout[s];
               stall_lst[s]  = lout[s];
            end
         end
      end
   end

   // ---------------- test sequence ----------------
   initial begin
      logic [63:0] w [$];
      rst = 1'b1;
      rmode = 0; gap_pct = 0;
      for (int s = 0; s < 2; s++) begin
         din[s] = '0; vin[s] = 1'b0; lin[s] = 1'b0; rout[s] = 1'b1;
         exp_good[s] = 0; exp_err[s] = 0; seen_err[s] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      zero_check("reset");
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_reset_ready0", rin[0], 1);
      chk("post_reset_ready1", rin[1], 1);

      // T1: reference frame, no stalls
      build_std(0, 10, w); send_pkt(0, w); drain();
      chk("t1_eth_const", ethv[0], {64'h0, {16{8'hA1}}});
      chk("t1_ip_const", ipv[0], {32'h0, {20{8'hB2}}});
      chk("t1_tcp_const", tcpv[0], {32'h0, {20{8'hC3}}});

      // T2: toggling downstream ready and random input gaps
      rmode = 1; gap_pct = 30;
      build_std(0, 10, w); send_pkt(0, w); drain();

      // T3: packet ends inside IP header; headers must keep prior values
      rmode = 2; gap_pct = 20;
      build_rand(0, 7, w); send_pkt(0, w); drain();
      chk("t3_eth_kept", ethv[0], last_eth);
      chk("t3_tcp_kept", tcpv[0], last_tcp);
      build_std(0, 10, w); send_pkt(0, w); drain();

      // T4 and boundaries: oversize, exactly-at-cap, one-over, header-only
      build_std(0, 20, w); send_pkt(0, w); drain();
      build_rand(0, 14 + MAXP, w); send_pkt(0, w);
      build_rand(0, 15 + MAXP, w); send_pkt(0, w);
      build_rand(0, 14, w); send_pkt(0, w);
      build_rand(0, 13, w); send_pkt(0, w);
      drain();

      // randomized back-to-back packets on the 32-bit instance
      for (int p = 0; p < 25; p++) begin
         rmode = $urandom_range(2);
         gap_pct = $urandom_range(40);
         build_rand(0, $urandom_range(1, 36), w);
         send_pkt(0, w);
      end
      drain();

      // T5: 64-bit instance
      rmode = 0; gap_pct = 0;
      build_std(1, 5, w); send_pkt(1, w); drain();
      chk("t5_eth_const", ethv[1], {64'h0, {16{8'hA1}}});
      rmode = 2; gap_pct = 25;
      for (int p = 0; p < 10; p++) begin
         build_rand(1, $urandom_range(1, 28), w);
         send_pkt(1, w);
      end
      drain();

      // T6: reset in the middle of the payload
      rmode = 0; gap_pct = 0;
      build_std(0, 10, w);
      model_pkt(0, w);
      drive(0, w, 15);
      #2;
      rst = 1'b1;
      #1;
      zero_check("mid_reset");
      qpay.delete(); qeth.delete(); qip.delete(); qtcp.delete();
      for (int s = 0; s < 2; s++) begin
         exp_good[s] = 0; exp_err[s] = 0; seen_err[s] = 0;
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      build_std(0, 10, w); send_pkt(0, w); drain();
      chk("t6_eth_const", ethv[0], {64'h0, {16{8'hA1}}});

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
